// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   OP_*         request operation codes (size in op[1:0], zero-extend in op[2])
//   lsu_state_e  controller states
//   op_valid     legal op for the given direction
//   misaligned   alignment check of a byte address against the access size
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

  // Unsigned variants only make sense for loads.
  function automatic logic op_valid(input logic [2:0] op, input logic we);
    case (op)
      OP_B, OP_H, OP_W: return 1'b1;
      OP_BU, OP_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the EX stage, the load/store unit and
// write-back.
//   master : EX/write-back side (drives requests, consumes responses)
//   slave  : load/store unit
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_is_load;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
  );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses on a word-wide memory (little-endian).
//   old_word/wdata/st_lane/st_half -> merged_word : store merge, byte or half
//   ld_word/ld_lane/ld_op          -> ld_result   : load extract + extend
module lsu_align (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  st_lane,
  input  logic        st_half,
  output logic [31:0] merged_word,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lane,
  input  logic [2:0]  ld_op,
  output logic [31:0] ld_result
);

  logic [31:0] shifted;

  always_comb begin
    merged_word = old_word;
    if (st_half) begin
      if (st_lane[1]) merged_word[31:16] = wdata[15:0];
      else            merged_word[15:0]  = wdata[15:0];
    end else begin
      merged_word[{st_lane, 3'b000} +: 8] = wdata[7:0];
    end
  end

  assign shifted = ld_word >> {ld_lane, 3'b000};

  always_comb begin
    case (ld_op[1:0])
      2'b00:   ld_result = ld_op[2] ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_result = ld_op[2] ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_result = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller in front of a word-only data memory.
// Byte/half loads are extracted from the read word; byte/half stores are
// done as read (accept cycle) then merged write (MERGE).
//   clk, rst       clock, synchronous active-high reset
//   bus            request/response handshake (slave side)
//   mem_*          word-addressed memory port; read data is asynchronous
//
// state | meaning
// IDLE  | ready for a request; performs the single-cycle memory access
// MERGE | writes the merged word of a sub-word store
// RESP  | holds the result until write-back takes it
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_writeData,
  output logic                mem_memWrite,
  output logic                mem_memRead,
  input  logic [31:0]         mem_readData
);

  lsu_state_e  state, state_next;

  logic        accept;
  logic        fault_in;
  logic        range_fault;
  logic        sub_store;
  logic        rd_en, wr_en;
  logic [31:0] word_idx;

  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_is_load_q;
  logic        resp_fault_q;

  logic [29:0] lat_addr;
  logic [1:0]  lat_lane;
  logic        lat_half;
  logic [31:0] lat_word;
  logic [31:0] lat_wdata;

  logic [31:0] merged_word;
  logic [31:0] ld_result;

  assign word_idx    = {2'b00, bus.req_addr[31:2]};
  assign range_fault = word_idx >= 32'(MEM_DEPTH);
  assign fault_in    = !op_valid(bus.req_op, bus.req_we)
                    || misaligned(bus.req_op, bus.req_addr[1:0])
                    || range_fault;
  assign sub_store   = bus.req_we && (bus.req_op[1:0] != 2'b10);
  assign accept      = bus.req_valid && bus.req_ready;

  lsu_align u_align (
    .old_word    (lat_word),
    .wdata       (lat_wdata),
    .st_lane     (lat_lane),
    .st_half     (lat_half),
    .merged_word (merged_word),
    .ld_word     (mem_readData),
    .ld_lane     (bus.req_addr[1:0]),
    .ld_op       (bus.req_op),
    .ld_result   (ld_result)
  );

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    mem_address   = {bus.req_addr[31:2], 2'b00};
    mem_writeData = bus.req_wdata;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!fault_in) begin
            if (bus.req_we && !sub_store) wr_en = 1'b1;
            else                          rd_en = 1'b1;
          end
          state_next = (sub_store && !fault_in) ? MERGE : RESP;
        end
      end
      MERGE: begin
        mem_address   = {lat_addr, 2'b00};
        mem_writeData = merged_word;
        wr_en         = 1'b1;
        state_next    = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset blocks the enables immediately so a reset landing on the MERGE
  // write cannot corrupt memory.
  assign mem_memRead  = rd_en && !rst;
  assign mem_memWrite = wr_en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      resp_data_q    <= '0;
      resp_rd_q      <= '0;
      resp_is_load_q <= 1'b0;
      resp_fault_q   <= 1'b0;
      lat_addr       <= '0;
      lat_lane       <= '0;
      lat_half       <= 1'b0;
      lat_word       <= '0;
      lat_wdata      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        resp_rd_q      <= bus.req_rd;
        resp_is_load_q <= !bus.req_we;
        resp_fault_q   <= fault_in;
        resp_data_q    <= (!bus.req_we && !fault_in) ? ld_result : 32'd0;
        if (sub_store && !fault_in) begin
          lat_addr  <= bus.req_addr[31:2];
          lat_lane  <= bus.req_addr[1:0];
          lat_half  <= bus.req_op[0];
          lat_word  <= mem_readData;
          lat_wdata <= bus.req_wdata;
        end
      end
    end
  end

  assign bus.resp_valid   = (state == RESP);
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_rd      = resp_rd_q;
  assign bus.resp_is_load = resp_is_load_q;
  assign bus.resp_fault   = resp_fault_q;

endmodule
